nv_nvdla_sdp_pipe_skid_fifo: RTL

// - Parametrised SDP valid/ready pipe stage: registered upstream ready, DEPTH-entry skid FIFO, registered output.
// - Sits between SDP cmux/datapath stages so long wires stay decoupled and ready carries no combinational path.
// - Adds over the single-entry skid stage: configurable width and skid depth, same-cycle bypass, sync flush, occupancy report.

---
 rtl/nv_nvdla_sdp_pipe_pkg.sv | 22 ++
 rtl/nv_nvdla_sdp_pipe_ram.sv | 27 ++
 rtl/nv_nvdla_sdp_pipe_skid_fifo.sv | 121 ++++++++++++
 3 files changed

// File: rtl/nv_nvdla_sdp_pipe_pkg.sv
// Shared constants and helpers for the SDP pipe skid FIFO.
package nv_nvdla_sdp_pipe_pkg;

  localparam int STALL_CNT_W = 32;
  localparam logic [STALL_CNT_W-1:0] STALL_CNT_MAX = 32'hFFFF_FFFF;

  // ceil(log2(n)), never below 1 so single-entry arrays still get an address bit
  function automatic int occ_width(input int n);
    int w;
    int p;
    w = 32'sd1;
    p = 32'sd2;
    for (int i = 0; i < 31; i++) begin
      if (p < n) begin
        p = p * 32'sd2;
        w = w + 32'sd1;
      end
    end
    return w;
  endfunction

endpackage

// File: rtl/nv_nvdla_sdp_pipe_ram.sv
// DEPTH x DW skid storage: one synchronous write port, asynchronous read of the head.
module nv_nvdla_sdp_pipe_ram
  import nv_nvdla_sdp_pipe_pkg::*;
#(
  parameter int DW    = 512,
  parameter int DEPTH = 2,
  parameter int AW    = occ_width(DEPTH)
) (
  input  logic          i_clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [DW-1:0] i_wdata,
  input  logic [AW-1:0] i_raddr,
  output logic [DW-1:0] o_rdata
);

  logic [DW-1:0] r_mem [DEPTH];

  always_ff @(posedge i_clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/nv_nvdla_sdp_pipe_skid_fifo.sv
// SDP valid/ready pipe stage: registered ready, DEPTH-entry skid FIFO, registered output.
// Optional stall counter on perf_stall_cnt when SDP_PIPE_PERF_EN is defined.
module nv_nvdla_sdp_pipe_skid_fifo
  import nv_nvdla_sdp_pipe_pkg::*;
#(
  parameter int DW    = 512,
  parameter int DEPTH = 2,
  parameter int OCC_W = occ_width(DEPTH + 2)
) (
  input  logic                   nvdla_core_clk,
  input  logic                   nvdla_core_rst,
  input  logic                   in_pvld,
  output logic                   in_prdy,
  input  logic [DW-1:0]          in_pd,
  output logic                   out_pvld,
  input  logic                   out_prdy,
  output logic [DW-1:0]          out_pd,
  input  logic                   flush,
  output logic [OCC_W-1:0]       occ
`ifdef SDP_PIPE_PERF_EN
 ,output logic [STALL_CNT_W-1:0] perf_stall_cnt
`endif
);

  localparam int AW = occ_width(DEPTH);

  logic [OCC_W-1:0] r_count, w_count_nxt, r_occ, w_occ_nxt;
  logic [AW-1:0]    r_wptr, r_rptr, w_wptr_inc, w_rptr_inc;
  logic             r_in_prdy, r_out_pvld, w_in_prdy_nxt, w_out_pvld_nxt;
  logic [DW-1:0]    r_out_pd, w_head;
  logic             w_accept, w_ld, w_empty, w_fifo_wr, w_fifo_rd;

  assign w_accept  = in_pvld & r_in_prdy;
  assign w_ld      = ~r_out_pvld | out_prdy;
  assign w_empty   = (r_count == '0);
  assign w_fifo_rd = w_ld & ~w_empty;
  // Only the bypass case (empty FIFO, output free) keeps an accepted beat out of the FIFO
  assign w_fifo_wr = w_accept & ~(w_ld & w_empty);

  assign w_wptr_inc = (r_wptr == AW'(DEPTH - 1)) ? '0 : r_wptr + AW'(1);
  assign w_rptr_inc = (r_rptr == AW'(DEPTH - 1)) ? '0 : r_rptr + AW'(1);

  always_comb begin
    w_count_nxt    = r_count + OCC_W'(w_fifo_wr) - OCC_W'(w_fifo_rd);
    w_out_pvld_nxt = w_ld ? (~w_empty | w_accept) : 1'b1;
    w_in_prdy_nxt  = 1'b0;
    if (flush) begin
      w_count_nxt    = '0;
      w_out_pvld_nxt = 1'b0;
      w_in_prdy_nxt  = 1'b0;
    end else begin
      w_in_prdy_nxt  = (w_count_nxt < OCC_W'(DEPTH));
    end
    w_occ_nxt = w_count_nxt + OCC_W'(w_out_pvld_nxt);
  end

  always_ff @(posedge nvdla_core_clk or posedge nvdla_core_rst) begin
    if (nvdla_core_rst) begin
      r_count    <= '0;
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_in_prdy  <= 1'b1;
      r_out_pvld <= 1'b0;
      r_occ      <= '0;
    end else begin
      r_count    <= w_count_nxt;
      r_in_prdy  <= w_in_prdy_nxt;
      r_out_pvld <= w_out_pvld_nxt;
      r_occ      <= w_occ_nxt;
      if (flush) begin
        r_wptr <= '0;
        r_rptr <= '0;
      end else begin
        if (w_fifo_wr) r_wptr <= w_wptr_inc;
        if (w_fifo_rd) r_rptr <= w_rptr_inc;
      end
    end
  end

  // Payload is unreset; it is only meaningful while out_pvld is high
  always_ff @(posedge nvdla_core_clk) begin
    if (w_ld) begin
      r_out_pd <= w_empty ? in_pd : w_head;
    end
  end

  nv_nvdla_sdp_pipe_ram #(
    .DW    (DW),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_ram (
    .i_clk   (nvdla_core_clk),
    .i_we    (w_fifo_wr),
    .i_waddr (r_wptr),
    .i_wdata (in_pd),
    .i_raddr (r_rptr),
    .o_rdata (w_head)
  );

  assign in_prdy  = r_in_prdy;
  assign out_pvld = r_out_pvld;
  assign out_pd   = r_out_pd;
  assign occ      = r_occ;

`ifdef SDP_PIPE_PERF_EN
  logic [STALL_CNT_W-1:0] r_stall_cnt;

  always_ff @(posedge nvdla_core_clk or posedge nvdla_core_rst) begin
    if (nvdla_core_rst) begin
      r_stall_cnt <= '0;
    end else if (flush) begin
      r_stall_cnt <= '0;
    end else if (r_out_pvld && !out_prdy && (r_stall_cnt != STALL_CNT_MAX)) begin
      r_stall_cnt <= r_stall_cnt + 32'd1;
    end
  end

  assign perf_stall_cnt = r_stall_cnt;
`endif

endmodule
